mdu_ctrl: RTL and testbench
===========================

# mdu_ctrl

Sequenced multiply/divide unit for the five-stage MIPS core. Sits beside the single-cycle ALU in the execute stage and owns the architectural HI/LO registers. MULT/MULTU/DIV/DIVU run on one shared 33-bit add/subtract datapath. An FSM steps that datapath for 32 iterations, asserts `busy` to the hazard unit for the duration, and commits the result to HI/LO.

## Interface
Parameters:
- `ITER`, default 32: number of iteration cycles per multiply/divide. Fixed at 32 for the 32-bit core; only reduced in unit benches.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `start`  in  1  execute stage issues an op this cycle
- `op`  in  3  encoding: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 reserved, treated as no-op
- `a`  in  32  rs value; dividend or multiplicand; MTHI/MTLO source
- `b`  in  32  rt value; divisor or multiplier
- `flush`  in  1  abort (exception/redirect) any op in flight or being issued
- `busy`  out  1  HI/LO not yet valid; hazard unit stalls MFHI/MFLO and any new MDU op
- `hi`  out  32  current HI register
- `lo`  out  32  current LO register

## Operation
- FSM states: IDLE, MUL, DIV. 6-bit iteration counter `cnt`.
- Issue is accepted only when `start` is high, state is IDLE and `flush` is low. `start` in any other state is ignored. No queuing.
- MTHI/MTLO:
  - HI or LO is set to `a` at the end of the issue cycle.
  - State stays IDLE; `busy` is never asserted.
- MULT/DIV issue:
  - Latch sign flags `sa = a[31] & signed_op` and `sb = b[31] & signed_op`.
  - Latch magnitudes `|a|` and `|b|`; unsigned ops take raw values.
  - Latch `b_zero = (b == 0)`.
  - Set `cnt = ITER` and enter MUL or DIV.
- MUL: shift-add, LSB-first.
  - Per cycle: if multiplier LSB is 1, add the multiplicand into the upper accumulator with a 33-bit carry.
  - Then shift the {acc, multiplier} pair right by 1.
- DIV: restoring division.
  - Per cycle: shift the {rem, quo} pair left by 1 and trial-subtract the divisor from the upper 33 bits.
  - Keep the difference and set quotient bit 1 if the result is non-negative. Otherwise restore and set 0.
- `cnt` decrements each iteration cycle. On the cycle with `cnt == 1`, the final iteration result is sign-corrected and written:
  - MUL: `{HI,LO}` = 64-bit product, negated (two's complement) if `sa ^ sb`.
  - DIV: LO = quotient, negated if `sa ^ sb`; HI = remainder, negated if `sa`.
  - DIV with `b_zero`: HI/LO unchanged. The op still takes full latency.
  - Signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (wraps, no trap).
  - State returns to IDLE.
- Flush:
  - In MUL/DIV: next state is IDLE and HI/LO are unchanged, even if this is the final cycle.
  - In IDLE with `start`: the issue is dropped, including MTHI/MTLO.
- Reset (`resetn` low at a clock edge) from any state, including mid-op:
  - State goes to IDLE, `cnt = 0`, HI = LO = 0, internal datapath registers cleared.

## Timing
- Reset values: `busy` 0, `hi` 0x00000000, `lo` 0x00000000.
- `busy` = (state != IDLE) | (`start` & IDLE & !`flush` & op∈{0..3}). It is combinational, so a consumer in the issue cycle already sees the stall.
- MULT/DIV issue accepted in cycle T:
  - `busy` is high in cycles T..T+ITER.
  - HI/LO are written at the edge ending cycle T+ITER and are visible, with `busy` low, in T+ITER+1.
  - An MFHI may therefore proceed in T+ITER+1; a new MDU op may issue in T+ITER+1.
- MTHI/MTLO in cycle T: new value visible on `hi`/`lo` in T+1. No stall.
- `hi`/`lo` are registered outputs and change only at a write or reset.
- `flush` takes effect at the same edge; `busy` is low the following cycle.

## Test plan
- Reset, then MULT a=0xFFFFFFFF, b=0x00000002 → `busy` high for 33 cycles (T..T+32); HI=0xFFFFFFFF, LO=0xFFFFFFFE at T+33.
- MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE. Then MULTU 0xFFFFFFFF×0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x12345678 and MTLO 0x9ABCDEF0 → visible next cycle with `busy` never high. Then DIVU 5/0 → 33 busy cycles, HI/LO still 0x12345678/0x9ABCDEF0.
- Start DIVU, pulse `flush` at cycle T+10 → `busy` low at T+11, HI/LO unchanged. Also check:
  - `start` for MTLO during busy → ignored.
  - `start` with `flush` in the same cycle → dropped.
- Start MULT, drop `resetn` at T+20 → HI=LO=0, `busy`=0 the next cycle. A new MULTU issued after reset completes normally.

Source files
------------

// File: rtl/mdu_if.sv
// Execute-stage <-> multiply/divide unit handshake: issue, operands, abort, and HI/LO readout.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, flush, input  busy, hi, lo);
    modport slave  (input  start, op, a, b, flush, output busy, hi, lo);
endinterface

// File: rtl/mdu_ctrl.sv
// Sequenced MULT/MULTU/DIV/DIVU on one shared 33-bit add/sub datapath; owns architectural HI/LO.
module mdu_ctrl #(
    parameter int unsigned ITER = 32
) (
    input  logic  clk,
    input  logic  resetn,
    mdu_if.slave  mdu
);
    typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;

    localparam logic [2:0] OP_MTHI = 3'd4;
    localparam logic [2:0] OP_MTLO = 3'd5;
    localparam logic [5:0] ITER_C  = 6'(ITER);

    state_e      state_q;
    logic [5:0]  cnt_q;
    logic        sa_q, sb_q, bz_q;
    // acc_q: product upper half / remainder; lsw_q: multiplier->product low / dividend->quotient
    logic [31:0] acc_q, lsw_q, opd_q;
    logic [31:0] hi_q, lo_q;

    logic        issue, arith_op, signed_op, sub;
    logic [31:0] abs_a, abs_b;
    logic [32:0] opa;
    logic [33:0] addend, sum;
    logic [31:0] acc_d, lsw_d;
    logic [63:0] prod_mag, prod_d;
    logic [31:0] quo_d, rem_d;

    assign issue     = mdu.start & (state_q == IDLE) & ~mdu.flush;
    assign arith_op  = ~mdu.op[2];
    assign signed_op = ~mdu.op[0];
    assign abs_a     = (signed_op & mdu.a[31]) ? 32'(-mdu.a) : mdu.a;
    assign abs_b     = (signed_op & mdu.b[31]) ? 32'(-mdu.b) : mdu.b;

    // Single adder: DIV subtracts via inverted operand plus carry-in.
    always_comb begin
        sub    = (state_q == DIV);
        opa    = sub ? {acc_q, lsw_q[31]} : {1'b0, acc_q};
        addend = sub ? ~{2'b00, opd_q} : (lsw_q[0] ? {2'b00, opd_q} : 34'd0);
        sum    = {1'b0, opa} + addend + {33'd0, sub};
        if (sub) begin
            acc_d = sum[33] ? opa[31:0] : sum[31:0];
            lsw_d = {lsw_q[30:0], ~sum[33]};
        end else begin
            acc_d = sum[32:1];
            lsw_d = {sum[0], lsw_q[31:1]};
        end
        prod_mag = {acc_d, lsw_d};
        prod_d   = (sa_q ^ sb_q) ? 64'(-prod_mag) : prod_mag;
        quo_d    = (sa_q ^ sb_q) ? 32'(-lsw_d) : lsw_d;
        rem_d    = sa_q ? 32'(-acc_d) : acc_d;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            bz_q    <= 1'b0;
            acc_q   <= '0;
            lsw_q   <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        if (arith_op) begin
                            sa_q    <= mdu.a[31] & signed_op;
                            sb_q    <= mdu.b[31] & signed_op;
                            bz_q    <= (mdu.b == 32'd0);
                            acc_q   <= '0;
                            lsw_q   <= mdu.op[1] ? abs_a : abs_b;
                            opd_q   <= mdu.op[1] ? abs_b : abs_a;
                            cnt_q   <= ITER_C;
                            state_q <= mdu.op[1] ? DIV : MUL;
                        end else if (mdu.op == OP_MTHI) begin
                            hi_q <= mdu.a;
                        end else if (mdu.op == OP_MTLO) begin
                            lo_q <= mdu.a;
                        end
                    end
                end
                MUL, DIV: begin
                    if (mdu.flush) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        lsw_q <= lsw_d;
                        cnt_q <= cnt_q - 6'd1;
                        if (cnt_q == 6'd1) begin
                            state_q <= IDLE;
                            if (state_q == MUL) begin
                                {hi_q, lo_q} <= prod_d;
                            end else if (!bz_q) begin
                                hi_q <= rem_d;
                                lo_q <= quo_d;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mdu.busy = (state_q != IDLE) | (issue & arith_op);
    assign mdu.hi   = hi_q;
    assign mdu.lo   = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized + directed bench for mdu_ctrl against a 64-bit arithmetic reference of HI/LO.
module tb_mdu_ctrl;
    localparam int ITER = 32;

    logic clk = 1'b0;
    logic resetn;
    mdu_if bus ();

    mdu_ctrl #(.ITER(ITER)) dut (.clk(clk), .resetn(resetn), .mdu(bus.slave));

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] m_hi, m_lo;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit arithmetic, C-style truncating division.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sx, sy, q, r;
        logic [63:0] p, qv, rv;
        sx = longint'($signed(a));
        sy = longint'($signed(b));
        case (op)
            3'd0: begin p = 64'(sx * sy); {m_hi, m_lo} = p; end
            3'd1: begin p = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = p; end
            3'd2: if (b != 0) begin
                q = sx / sy; r = sx % sy; qv = q; rv = r;
                m_lo = qv[31:0]; m_hi = rv[31:0];
            end
            3'd3: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
            3'd4: m_hi = a;
            3'd5: m_lo = a;
            default: ;
        endcase
    endtask

    task automatic drive_idle();
        bus.start = 1'b0; bus.flush = 1'b0; bus.op = 3'd7; bus.a = '0; bus.b = '0;
    endtask

    // Issue one op, count busy cycles from the issue cycle on, then check HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int bcnt;
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        bcnt = bus.busy ? 1 : 0;
        @(posedge clk); #1;
        drive_idle();
        for (int i = 0; i < ITER + 5; i++) begin
            @(negedge clk);
            if (!bus.busy) break;
            bcnt++;
        end
        model(op, a, b);
        chk({tag, "_busy"}, 32'(bcnt), (op < 3'd4) ? 32'(ITER + 1) : 32'd0);
        chk({tag, "_hi"}, bus.hi, m_hi);
        chk({tag, "_lo"}, bus.lo, m_lo);
    endtask

    task automatic adv(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;
        drive_idle();
        m_hi = '0; m_lo = '0;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);

        do_op("mult", 3'd0, 32'hFFFFFFFF, 32'h2);
        chk("mult_hi_const", bus.hi, 32'hFFFFFFFF);
        chk("mult_lo_const", bus.lo, 32'hFFFFFFFE);
        do_op("multu", 3'd1, 32'hFFFFFFFF, 32'h2);
        do_op("multu_max", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
        do_op("div_neg", 3'd2, 32'hFFFFFFF9, 32'h2);
        chk("div_neg_lo_const", bus.lo, 32'hFFFFFFFD);
        do_op("divu", 3'd3, 32'd7, 32'd2);
        do_op("div_ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF);
        do_op("mthi", 3'd4, 32'h12345678, 32'h0);
        do_op("mtlo", 3'd5, 32'h9ABCDEF0, 32'h0);
        do_op("divu_z", 3'd3, 32'd5, 32'd0);
        chk("divu_z_hi_const", bus.hi, 32'h12345678);

        // Flush mid-DIVU at T+10, with an MTLO attempt while busy at T+5.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 32'd1000; bus.b = 32'd3;
        adv(1); drive_idle();                       // T+1
        adv(4);                                     // T+5
        bus.start = 1'b1; bus.op = 3'd5; bus.a = 32'hDEADBEEF;
        @(negedge clk);
        chk("mtlo_busy_busy", 32'(bus.busy), 32'd1);
        adv(1); drive_idle();                       // T+6
        adv(4); bus.flush = 1'b1;                   // T+10
        adv(1); bus.flush = 1'b0;                   // T+11
        @(negedge clk);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        chk("flush_hi", bus.hi, m_hi);
        chk("flush_lo", bus.lo, m_lo);

        // start with flush in the same cycle is dropped.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 3'd4; bus.a = 32'hCAFEF00D;
        @(negedge clk);
        chk("stfl_mt_busy", 32'(bus.busy), 32'd0);
        bus.op = 3'd0;
        #1 chk("stfl_mul_busy", 32'(bus.busy), 32'd0);
        adv(1); drive_idle();
        @(negedge clk);
        chk("stfl_busy2", 32'(bus.busy), 32'd0);
        chk("stfl_hi", bus.hi, m_hi);
        chk("stfl_lo", bus.lo, m_lo);

        // Flush on the final iteration cycle still suppresses the write.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd1; bus.a = 32'd77; bus.b = 32'd99;
        adv(1); drive_idle();                       // T+1
        adv(ITER - 1); bus.flush = 1'b1;            // T+ITER
        adv(1); bus.flush = 1'b0;
        @(negedge clk);
        chk("lastfl_busy", 32'(bus.busy), 32'd0);
        chk("lastfl_hi", bus.hi, m_hi);
        chk("lastfl_lo", bus.lo, m_lo);

        // Reset mid-MULT at T+20.
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 32'h1234; bus.b = 32'h5678;
        adv(1); drive_idle();                       // T+1
        adv(19); resetn = 1'b0;                     // T+20
        adv(1); resetn = 1'b1;                      // T+21
        @(negedge clk);
        m_hi = '0; m_lo = '0;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        do_op("post_rst_multu", 3'd1, 32'hDEADBEEF, 32'h00010001);

        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'($urandom_range(0, 100));
                default: ;
            endcase
            do_op("rand", rop, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=%0d", n_vec, 0);
        $fatal(1, "timeout");
    end
endmodule
